el2_dbg_cmd_seq: RTL and testbench
==================================

Name: el2_dbg_cmd_seq

Overview:
- Sequences debug abstract commands (GPR/CSR read/write) from the debug module into the decode-stage debug injection path.
- Accepts one command at a time. Waits until the core is halted and the pipe is idle, then issues a single-cycle dbg_cmd_valid to decode.
- Waits for the writeback completion or fail, then returns a response to the debug module.
- Sits between the debug module and el2_dec; it owns the dbg_cmd_* bus.

Parameters:
TIMEOUT, 256, max cycles spent in WAIT_HALT plus WAIT_DONE before the command is aborted with a timeout error; legal range 2..65535.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
dm_cmd_valid  in  1  debug-module command valid
dm_cmd_ready  out  1  sequencer can accept a command
dm_cmd_write  in  1  command is a write
dm_cmd_type  in  2  0=GPR, 1=CSR, 2=memory, 3=reserved
dm_cmd_addr  in  32  GPR index [4:0] or CSR address [11:0]
dm_cmd_wrdata  in  32  write data
core_halted  in  1  core is in debug halt
pipe_idle  in  1  no instruction in flight, D through WB
dbg_cmd_valid  out  1  one-cycle injection strobe to decode
dbg_cmd_write  out  1  registered copy of the command write bit
dbg_cmd_type  out  2  registered copy of the command type
dbg_cmd_addr  out  32  registered copy of the command address
dbg_cmd_wrdata  out  32  registered copy of the write data
dec_dbg_cmd_done  in  1  injected instruction completed at writeback
dec_dbg_cmd_fail  in  1  injected instruction faulted; qualified by done
dec_dbg_rddata  in  32  read result; valid with done
dm_rsp_valid  out  1  response valid
dm_rsp_ready  in  1  debug module accepts the response
dm_rsp_err  out  2  0=ok, 1=core fail, 2=unsupported type, 3=timeout
dm_rsp_rdata  out  32  read data; 0 for writes and all errors
dbg_busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - All outputs go to 0, except dm_cmd_ready=1.
  - Timeout counter and command registers clear.
  - Reset asserted mid-command discards the command silently; no response is produced.
- States: IDLE, WAIT_HALT, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - dm_cmd_ready=1 only in IDLE.
  - On dm_cmd_valid&dm_cmd_ready, latch write/type/addr/wrdata into the dbg_cmd_* registers.
  - If type is 2 or 3: go to RESP with err=2; no injection.
  - Otherwise: go to WAIT_HALT and clear the counter.
- WAIT_HALT:
  - When core_halted&pipe_idle, go to ISSUE.
  - Otherwise increment the counter; when counter reaches TIMEOUT-1, go to RESP with err=3.
- ISSUE:
  - dbg_cmd_valid=1 for exactly this one cycle; dbg_cmd_* fields are stable.
  - Next state is always WAIT_DONE. dec_dbg_cmd_done is ignored in ISSUE.
  - Counter continues counting.
- WAIT_DONE:
  - On done&~fail: err=0; rdata=dec_dbg_rddata for a read, 0 for a write; go to RESP.
  - On done&fail: err=1, rdata=0; go to RESP.
  - Otherwise increment the counter; when counter reaches TIMEOUT-1, go to RESP with err=3.
  - If done and timeout occur in the same cycle, done wins.
  - Loss of core_halted during WAIT_DONE is ignored.
- Counter:
  - Width $clog2(TIMEOUT+1); saturates and never wraps.
  - One counter spans WAIT_HALT, ISSUE and WAIT_DONE (total budget).
- RESP:
  - dm_rsp_valid=1; err and rdata are held stable until dm_rsp_ready.
  - On dm_rsp_valid&dm_rsp_ready, return to IDLE. A new command can be accepted no earlier than the following cycle (no same-cycle turnaround).
- dbg_cmd_* field registers keep their last value after the command; only dbg_cmd_valid qualifies them.
- Minimum latency, with core already halted and idle:
  - command handshake at cycle 0;
  - ISSUE at cycle 2;
  - done earliest at cycle 3;
  - dm_rsp_valid at cycle 4.

Test Plan:
- Reset then idle: rst pulse -> dm_cmd_ready=1, dbg_cmd_valid=0, dm_rsp_valid=0, dbg_busy=0.
- GPR read x5 with core_halted=pipe_idle=1 (type=0, addr=5, write=0); done with rddata=0xDEADBEEF two cycles after ISSUE -> dbg_cmd_valid high exactly 1 cycle, dbg_cmd_addr=5; response err=0, rdata=0xDEADBEEF.
- CSR write 0x7C4, wrdata=0x1, with core_halted low for 10 cycles then high -> no dbg_cmd_valid while low; one ISSUE pulse after both inputs go high; done -> err=0, rdata=0.
- Type=2 command -> no dbg_cmd_valid ever; response err=2 on the cycle after accept.
- TIMEOUT=16, core halted, done never arrives -> err=3 exactly 16 cycles after entering WAIT_HALT; also done&fail -> err=1.
- Hold dm_rsp_ready=0 for 5 cycles -> response held stable, dm_cmd_ready=0. Then assert rst during WAIT_DONE -> IDLE immediately, no response emitted.

Source files
------------

// File: rtl/el2_dbg_cmd_seq.sv
// el2_dbg_cmd_seq
// Sequences one debug abstract command (GPR/CSR read or write) from the debug
// module into the decode-stage debug injection path. It waits for the core to
// be halted with an idle pipe, issues a one-cycle dbg_cmd_valid strobe, waits
// for writeback completion or fault, and returns a response to the debug module.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   dm_cmd_*            command from debug module (valid/ready handshake)
//   core_halted         core is in debug halt
//   pipe_idle           no instruction in flight, D through WB
//   dbg_cmd_*           injection bus to decode; fields registered at accept
//   dec_dbg_cmd_done    injected instruction completed at writeback
//   dec_dbg_cmd_fail    injected instruction faulted (qualified by done)
//   dec_dbg_rddata      read result, valid with done
//   dm_rsp_*            response to debug module (valid/ready handshake)
//   dbg_busy            sequencer is not idle
module el2_dbg_cmd_seq #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        dm_cmd_valid,
  output logic        dm_cmd_ready,
  input  logic        dm_cmd_write,
  input  logic [1:0]  dm_cmd_type,
  input  logic [31:0] dm_cmd_addr,
  input  logic [31:0] dm_cmd_wrdata,

  input  logic        core_halted,
  input  logic        pipe_idle,

  output logic        dbg_cmd_valid,
  output logic        dbg_cmd_write,
  output logic [1:0]  dbg_cmd_type,
  output logic [31:0] dbg_cmd_addr,
  output logic [31:0] dbg_cmd_wrdata,

  input  logic        dec_dbg_cmd_done,
  input  logic        dec_dbg_cmd_fail,
  input  logic [31:0] dec_dbg_rddata,

  output logic        dm_rsp_valid,
  input  logic        dm_rsp_ready,
  output logic [1:0]  dm_rsp_err,
  output logic [31:0] dm_rsp_rdata,

  output logic        dbg_busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_FAIL    = 2'd1;
  localparam logic [1:0] ERR_UNSUPP  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
    ISSUE,
    WAIT_DONE,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  logic          cmd_load;
  logic          cnt_clr;
  logic          cnt_run;
  logic          rsp_load;
  logic          rsp_clr;
  logic [1:0]    rsp_err_nxt;
  logic [31:0]   rsp_rdata_nxt;

  assign timeout_hit   = (cnt >= CNT_LAST);

  assign dm_cmd_ready  = (state == IDLE);
  assign dbg_cmd_valid = (state == ISSUE);
  assign dm_rsp_valid  = (state == RESP);
  assign dbg_busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The counter runs every cycle in WAIT_HALT, ISSUE and WAIT_DONE, so the
  // timeout is a total budget measured from entry into WAIT_HALT.
  always_comb begin
    state_nxt     = state;
    cmd_load      = 1'b0;
    cnt_clr       = 1'b0;
    cnt_run       = 1'b0;
    rsp_load      = 1'b0;
    rsp_clr       = 1'b0;
    rsp_err_nxt   = ERR_OK;
    rsp_rdata_nxt = '0;

    unique case (state)
      IDLE: begin
        if (dm_cmd_valid) begin
          cmd_load = 1'b1;
          if (dm_cmd_type[1]) begin
            state_nxt   = RESP;
            rsp_load    = 1'b1;
            rsp_err_nxt = ERR_UNSUPP;
          end else begin
            state_nxt = WAIT_HALT;
            cnt_clr   = 1'b1;
          end
        end
      end

      WAIT_HALT: begin
        cnt_run = 1'b1;
        if (core_halted && pipe_idle) begin
          state_nxt = ISSUE;
        end else if (timeout_hit) begin
          state_nxt   = RESP;
          rsp_load    = 1'b1;
          rsp_err_nxt = ERR_TIMEOUT;
        end
      end

      ISSUE: begin
        cnt_run   = 1'b1;
        state_nxt = WAIT_DONE;
      end

      WAIT_DONE: begin
        cnt_run = 1'b1;
        // completion takes priority over a coincident timeout
        if (dec_dbg_cmd_done) begin
          state_nxt = RESP;
          rsp_load  = 1'b1;
          if (dec_dbg_cmd_fail) begin
            rsp_err_nxt = ERR_FAIL;
          end else begin
            rsp_err_nxt   = ERR_OK;
            rsp_rdata_nxt = dbg_cmd_write ? '0 : dec_dbg_rddata;
          end
        end else if (timeout_hit) begin
          state_nxt   = RESP;
          rsp_load    = 1'b1;
          rsp_err_nxt = ERR_TIMEOUT;
        end
      end

      RESP: begin
        if (dm_rsp_ready) begin
          state_nxt = IDLE;
          rsp_clr   = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_run && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_cmd_write  <= 1'b0;
      dbg_cmd_type   <= '0;
      dbg_cmd_addr   <= '0;
      dbg_cmd_wrdata <= '0;
    end else if (cmd_load) begin
      dbg_cmd_write  <= dm_cmd_write;
      dbg_cmd_type   <= dm_cmd_type;
      dbg_cmd_addr   <= dm_cmd_addr;
      dbg_cmd_wrdata <= dm_cmd_wrdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_rsp_err   <= '0;
      dm_rsp_rdata <= '0;
    end else if (rsp_load) begin
      dm_rsp_err   <= rsp_err_nxt;
      dm_rsp_rdata <= rsp_rdata_nxt;
    end else if (rsp_clr) begin
      dm_rsp_err   <= '0;
      dm_rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_el2_dbg_cmd_seq.sv
module tb_el2_dbg_cmd_seq;

  logic        clk;
  logic        rst;
  logic        dm_cmd_valid;
  logic        dm_cmd_ready;
  logic        dm_cmd_write;
  logic [1:0]  dm_cmd_type;
  logic [31:0] dm_cmd_addr;
  logic [31:0] dm_cmd_wrdata;
  logic        core_halted;
  logic        pipe_idle;
  logic        dbg_cmd_valid;
  logic        dbg_cmd_write;
  logic [1:0]  dbg_cmd_type;
  logic [31:0] dbg_cmd_addr;
  logic [31:0] dbg_cmd_wrdata;
  logic        dec_dbg_cmd_done;
  logic        dec_dbg_cmd_fail;
  logic [31:0] dec_dbg_rddata;
  logic        dm_rsp_valid;
  logic        dm_rsp_ready;
  logic [1:0]  dm_rsp_err;
  logic [31:0] dm_rsp_rdata;
  logic        dbg_busy;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  int rsp_cnt = 0;

  el2_dbg_cmd_seq #(.TIMEOUT(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .dm_cmd_valid     (dm_cmd_valid),
    .dm_cmd_ready     (dm_cmd_ready),
    .dm_cmd_write     (dm_cmd_write),
    .dm_cmd_type      (dm_cmd_type),
    .dm_cmd_addr      (dm_cmd_addr),
    .dm_cmd_wrdata    (dm_cmd_wrdata),
    .core_halted      (core_halted),
    .pipe_idle        (pipe_idle),
    .dbg_cmd_valid    (dbg_cmd_valid),
    .dbg_cmd_write    (dbg_cmd_write),
    .dbg_cmd_type     (dbg_cmd_type),
    .dbg_cmd_addr     (dbg_cmd_addr),
    .dbg_cmd_wrdata   (dbg_cmd_wrdata),
    .dec_dbg_cmd_done (dec_dbg_cmd_done),
    .dec_dbg_cmd_fail (dec_dbg_cmd_fail),
    .dec_dbg_rddata   (dec_dbg_rddata),
    .dm_rsp_valid     (dm_rsp_valid),
    .dm_rsp_ready     (dm_rsp_ready),
    .dm_rsp_err       (dm_rsp_err),
    .dm_rsp_rdata     (dm_rsp_rdata),
    .dbg_busy         (dbg_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count injection strobes and response handshakes away from the active edge.
  always @(negedge clk) begin
    if (dbg_cmd_valid) issue_cnt++;
    if (dm_rsp_valid && dm_rsp_ready) rsp_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [1:0] typ,
                          input logic [31:0] addr, input logic [31:0] wdata);
    dm_cmd_valid  = 1'b1;
    dm_cmd_write  = wr;
    dm_cmd_type   = typ;
    dm_cmd_addr   = addr;
    dm_cmd_wrdata = wdata;
  endtask

  // Pops the scoreboard and compares the presented response against it.
  task automatic check_rsp(input string tag);
    rsp_t e;
    chk({tag, "_valid"}, 32'(dm_rsp_valid), 32'd1);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_queue: observed empty scoreboard expected a queued response", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_err"}, 32'(dm_rsp_err), 32'(e.err));
      chk({tag, "_rdata"}, dm_rsp_rdata, e.rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    dm_cmd_valid = 1'b0; dm_cmd_write = 1'b0; dm_cmd_type = 2'd0;
    dm_cmd_addr = '0; dm_cmd_wrdata = '0;
    core_halted = 1'b0; pipe_idle = 1'b1;
    dec_dbg_cmd_done = 1'b0; dec_dbg_cmd_fail = 1'b0; dec_dbg_rddata = '0;
    dm_rsp_ready = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(dm_cmd_ready), 32'd1);
    chk("rst_dbg_valid", 32'(dbg_cmd_valid), 32'd0);
    chk("rst_rsp_valid", 32'(dm_rsp_valid), 32'd0);
    chk("rst_busy", 32'(dbg_busy), 32'd0);
    chk("rst_rsp_err", 32'(dm_rsp_err), 32'd0);
    chk("rst_rsp_rdata", dm_rsp_rdata, 32'd0);
    chk("rst_cmd_addr", dbg_cmd_addr, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", 32'(dm_cmd_ready), 32'd1);
    chk("idle_busy", 32'(dbg_busy), 32'd0);

    // GPR read x5, core already halted and idle
    core_halted = 1'b1;
    send_cmd(1'b0, 2'd0, 32'd5, 32'd0);
    exp_q.push_back({2'd0, 32'hDEADBEEF});
    tick();
    dm_cmd_valid = 1'b0;
    chk("gpr_busy", 32'(dbg_busy), 32'd1);
    chk("gpr_cmd_ready", 32'(dm_cmd_ready), 32'd0);
    chk("gpr_no_early_issue", 32'(dbg_cmd_valid), 32'd0);
    tick();
    chk("gpr_issue", 32'(dbg_cmd_valid), 32'd1);
    chk("gpr_addr", dbg_cmd_addr, 32'd5);
    chk("gpr_type", 32'(dbg_cmd_type), 32'd0);
    chk("gpr_write", 32'(dbg_cmd_write), 32'd0);
    tick();
    chk("gpr_issue_one_cycle", 32'(dbg_cmd_valid), 32'd0);
    tick();
    dec_dbg_cmd_done = 1'b1; dec_dbg_rddata = 32'hDEADBEEF;
    tick();
    dec_dbg_cmd_done = 1'b0; dec_dbg_rddata = '0;
    check_rsp("gpr_rsp");
    tick();
    chk("gpr_back_idle", 32'(dm_cmd_ready), 32'd1);
    chk("gpr_rsp_dropped", 32'(dm_rsp_valid), 32'd0);
    chk("gpr_issue_count", 32'(issue_cnt), 32'd1);

    // CSR write 0x7C4, core not halted for 10 cycles, then pipe busy 1 cycle
    core_halted = 1'b0;
    send_cmd(1'b1, 2'd1, 32'h7C4, 32'h1);
    exp_q.push_back({2'd0, 32'h0});
    tick();
    dm_cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("csr_wait_halt", 32'(dbg_cmd_valid), 32'd0);
    end
    core_halted = 1'b1; pipe_idle = 1'b0;
    tick();
    chk("csr_wait_pipe", 32'(dbg_cmd_valid), 32'd0);
    pipe_idle = 1'b1;
    tick();
    chk("csr_issue", 32'(dbg_cmd_valid), 32'd1);
    chk("csr_write", 32'(dbg_cmd_write), 32'd1);
    chk("csr_type", 32'(dbg_cmd_type), 32'd1);
    chk("csr_addr", dbg_cmd_addr, 32'h7C4);
    chk("csr_wrdata", dbg_cmd_wrdata, 32'h1);
    tick();
    dec_dbg_cmd_done = 1'b1; dec_dbg_rddata = 32'h55;
    tick();
    dec_dbg_cmd_done = 1'b0; dec_dbg_rddata = '0;
    check_rsp("csr_rsp");
    tick();
    chk("csr_issue_count", 32'(issue_cnt), 32'd2);

    // unsupported types: response on the cycle after accept, no injection
    send_cmd(1'b0, 2'd2, 32'h10, 32'hAB);
    exp_q.push_back({2'd2, 32'h0});
    tick();
    dm_cmd_valid = 1'b0;
    check_rsp("mem_rsp");
    chk("mem_no_issue", 32'(dbg_cmd_valid), 32'd0);
    chk("mem_type_latched", 32'(dbg_cmd_type), 32'd2);
    tick();
    send_cmd(1'b1, 2'd3, 32'h20, 32'hCD);
    exp_q.push_back({2'd2, 32'h0});
    tick();
    dm_cmd_valid = 1'b0;
    check_rsp("rsvd_rsp");
    tick();
    chk("unsupp_issue_count", 32'(issue_cnt), 32'd2);

    // timeout: done never arrives, err=3 exactly 16 cycles after WAIT_HALT entry
    send_cmd(1'b0, 2'd0, 32'd7, 32'd0);
    exp_q.push_back({2'd3, 32'h0});
    tick();
    dm_cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("tmo_not_yet", 32'(dm_rsp_valid), 32'd0);
    end
    tick();
    check_rsp("tmo_rsp");
    tick();
    chk("tmo_issue_count", 32'(issue_cnt), 32'd3);

    // core fault: err=1, rdata forced to 0
    send_cmd(1'b0, 2'd1, 32'h300, 32'd0);
    exp_q.push_back({2'd1, 32'h0});
    tick();
    dm_cmd_valid = 1'b0;
    tick();
    tick();
    dec_dbg_cmd_done = 1'b1; dec_dbg_cmd_fail = 1'b1; dec_dbg_rddata = 32'h123;
    tick();
    dec_dbg_cmd_done = 1'b0; dec_dbg_cmd_fail = 1'b0; dec_dbg_rddata = '0;
    check_rsp("fail_rsp");
    tick();

    // response back-pressure, then no same-cycle command turnaround
    dm_rsp_ready = 1'b0;
    send_cmd(1'b0, 2'd0, 32'd3, 32'd0);
    exp_q.push_back({2'd0, 32'hA5A5A5A5});
    tick();
    dm_cmd_valid = 1'b0;
    tick();
    tick();
    dec_dbg_cmd_done = 1'b1; dec_dbg_rddata = 32'hA5A5A5A5;
    tick();
    dec_dbg_cmd_done = 1'b0; dec_dbg_rddata = '0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(dm_rsp_valid), 32'd1);
      chk("hold_err", 32'(dm_rsp_err), 32'd0);
      chk("hold_rdata", dm_rsp_rdata, 32'hA5A5A5A5);
      chk("hold_cmd_ready", 32'(dm_cmd_ready), 32'd0);
      tick();
    end
    dm_rsp_ready = 1'b1;
    send_cmd(1'b0, 2'd2, 32'd0, 32'd0);
    check_rsp("hold_rsp");
    exp_q.push_back({2'd2, 32'h0});
    tick();
    chk("turnaround_ready", 32'(dm_cmd_ready), 32'd1);
    chk("turnaround_rsp", 32'(dm_rsp_valid), 32'd0);
    tick();
    dm_cmd_valid = 1'b0;
    check_rsp("turnaround_late_rsp");
    tick();
    chk("hold_rsp_count", 32'(rsp_cnt), 32'd8);

    // reset during WAIT_DONE discards the command silently
    send_cmd(1'b0, 2'd0, 32'd9, 32'd0);
    tick();
    dm_cmd_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(dbg_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(dbg_busy), 32'd0);
    chk("mid_rst_ready", 32'(dm_cmd_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(dm_rsp_valid), 32'd0);
    chk("mid_rst_addr", dbg_cmd_addr, 32'd0);
    tick();
    rst = 1'b0;
    dec_dbg_cmd_done = 1'b1;
    tick();
    dec_dbg_cmd_done = 1'b0;
    repeat (5) tick();
    chk("mid_rst_no_rsp", 32'(rsp_cnt), 32'd8);
    chk("mid_rst_idle", 32'(dbg_busy), 32'd0);
    chk("final_issue_count", 32'(issue_cnt), 32'd6);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
